// File: rtl/phase_meas_pkg.sv
// Shared constants for the N/Q phase measurement controller.
// Holds the FSM state encoding, the averaging depth (log2) and the default
// counter width that the display and LPF blocks also use.
package phase_meas_pkg;

   // Default width of the cycle counter and of the phase/period results.
   localparam int unsigned CNT_W_DEF = 16;

   // Number of periods averaged (as log2) when averaging is built in.
   localparam int unsigned AVG_LOG2 = 2;

   // FSM states
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_N  = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;

endpackage : phase_meas_pkg

// File: rtl/edge_sync_rise.sv
// Synchronizes one asynchronous input into the clk domain and emits a
// one-cycle registered pulse on each rising edge.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   d_i        : asynchronous input pin
//   rise_o     : one-cycle pulse, SYNC_STAGES+1 cycles after the pin rises
module edge_sync_rise #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;

   // Synchronizer chain, previous-value flop and registered rise detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule : edge_sync_rise

// File: rtl/phase_meas_ctrl.sv
// Phase/period measurement controller for encoder channels N and Q.
// Counts clkRef cycles from each N rise to the first following Q rise (phase)
// and to the next N rise (period), and publishes each result on a
// valid/ready handshake with timeout, missing-Q and overrun qualification.
// Optional averaging of 4 periods is built when PHASE_MEAS_AVG_EN is defined.
// Ports:
//   clkRef, rst_n          : clock, async active-low reset
//   enable                 : 1 = measure continuously, 0 = abort to idle
//   N, Q                   : asynchronous encoder channels
//   phase_cnt, period_cnt  : last published result
//   result_valid/ready     : result handshake
//   q_missing              : result qualifier, no Q rise in that period
//   timeout                : one-cycle pulse on counter saturation
//   overrun                : sticky, a result was dropped
//   busy                   : FSM in WAIT_N or MEASURE
module phase_meas_ctrl
   import phase_meas_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clkRef,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             N,
   input  logic             Q,
   output logic [CNT_W-1:0] phase_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             q_missing,
   output logic             timeout,
   output logic             overrun,
   output logic             busy
);

   // Last count value that still yields a reportable period (2^CNT_W-1)
   localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

   logic             n_rise, q_rise, hs_c;
   logic [CNT_W-1:0] cnt_inc_c;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_seen_q, q_seen_d;
   logic [CNT_W-1:0] phase_reg_q, phase_reg_d;
   logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic             valid_q, valid_d;
   logic             q_missing_q, q_missing_d;
   logic             timeout_q, timeout_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;

`ifdef PHASE_MEAS_AVG_EN
   localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
   logic [ACC_W-1:0]    acc_ph_q, acc_ph_d, acc_per_q, acc_per_d;
   logic [ACC_W-1:0]    sum_ph_c, sum_per_c;
   logic [AVG_LOG2-1:0] avg_n_q, avg_n_d;

   assign sum_ph_c  = acc_ph_q + ACC_W'(phase_reg_q);
   assign sum_per_c = acc_per_q + ACC_W'(cnt_inc_c);
`endif

   edge_sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_n (
      .clk(clkRef), .rst_n(rst_n), .d_i(N), .rise_o(n_rise)
   );

   edge_sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_q (
      .clk(clkRef), .rst_n(rst_n), .d_i(Q), .rise_o(q_rise)
   );

   assign hs_c      = valid_q & result_ready;
   assign cnt_inc_c = cnt_q + CNT_W'(1);

   // Next-state and output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      q_seen_d     = q_seen_q;
      phase_reg_d  = phase_reg_q;
      phase_cnt_d  = phase_cnt_q;
      period_cnt_d = period_cnt_q;
      valid_d      = valid_q;
      q_missing_d  = q_missing_q;
      timeout_d    = 1'b0;
      overrun_d    = overrun_q;
`ifdef PHASE_MEAS_AVG_EN
      acc_ph_d     = acc_ph_q;
      acc_per_d    = acc_per_q;
      avg_n_d      = avg_n_q;
`endif

      // Accepted result drops valid; a same-cycle publish below overrides
      if (hs_c) valid_d = 1'b0;

      if (!enable) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         q_seen_d  = 1'b0;
         overrun_d = 1'b0;
`ifdef PHASE_MEAS_AVG_EN
         acc_ph_d  = '0;
         acc_per_d = '0;
         avg_n_d   = '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d   = '0;
               state_d = ST_WAIT_N;
            end
            ST_WAIT_N: begin
               // A Q rise coincident with the opening N edge is ignored
               if (n_rise) begin
                  cnt_d    = '0;
                  q_seen_d = 1'b0;
                  state_d  = ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               cnt_d = cnt_inc_c;
               if (n_rise) begin
`ifdef PHASE_MEAS_AVG_EN
                  if (!q_seen_q) begin
                     acc_ph_d  = '0;
                     acc_per_d = '0;
                     avg_n_d   = '0;
                  end else if (avg_n_q == '1) begin
                     if (!valid_q || hs_c) begin
                        phase_cnt_d  = CNT_W'(sum_ph_c >> AVG_LOG2);
                        period_cnt_d = CNT_W'(sum_per_c >> AVG_LOG2);
                        q_missing_d  = 1'b0;
                        valid_d      = 1'b1;
                     end else begin
                        overrun_d = 1'b1;
                     end
                     acc_ph_d  = '0;
                     acc_per_d = '0;
                     avg_n_d   = '0;
                  end else begin
                     acc_ph_d  = sum_ph_c;
                     acc_per_d = sum_per_c;
                     avg_n_d   = avg_n_q + AVG_LOG2'(1);
                  end
`else
                  if (!valid_q || hs_c) begin
                     phase_cnt_d  = q_seen_q ? phase_reg_q : '0;
                     period_cnt_d = cnt_inc_c;
                     q_missing_d  = ~q_seen_q;
                     valid_d      = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
`endif
                  // Coincident Q rise opens the new period with phase 0
                  cnt_d       = '0;
                  q_seen_d    = q_rise;
                  phase_reg_d = '0;
               end else begin
                  if (q_rise && !q_seen_q) begin
                     phase_reg_d = cnt_inc_c;
                     q_seen_d    = 1'b1;
                  end
                  // Next count would exceed the largest reportable period
                  if (cnt_q == CNT_LAST) begin
                     timeout_d = 1'b1;
                     cnt_d     = '0;
                     q_seen_d  = 1'b0;
                     state_d   = ST_WAIT_N;
`ifdef PHASE_MEAS_AVG_EN
                     acc_ph_d  = '0;
                     acc_per_d = '0;
                     avg_n_d   = '0;
`endif
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State register
   always_ff @(posedge clkRef or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         q_seen_q     <= 1'b0;
         phase_reg_q  <= '0;
         phase_cnt_q  <= '0;
         period_cnt_q <= '0;
         valid_q      <= 1'b0;
         q_missing_q  <= 1'b0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
`ifdef PHASE_MEAS_AVG_EN
         acc_ph_q     <= '0;
         acc_per_q    <= '0;
         avg_n_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         q_seen_q     <= q_seen_d;
         phase_reg_q  <= phase_reg_d;
         phase_cnt_q  <= phase_cnt_d;
         period_cnt_q <= period_cnt_d;
         valid_q      <= valid_d;
         q_missing_q  <= q_missing_d;
         timeout_q    <= timeout_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
`ifdef PHASE_MEAS_AVG_EN
         acc_ph_q     <= acc_ph_d;
         acc_per_q    <= acc_per_d;
         avg_n_q      <= avg_n_d;
`endif
      end
   end

   assign phase_cnt    = phase_cnt_q;
   assign period_cnt   = period_cnt_q;
   assign result_valid = valid_q;
   assign q_missing    = q_missing_q;
   assign timeout      = timeout_q;
   assign overrun      = overrun_q;
   assign busy         = busy_q;

endmodule : phase_meas_ctrl

// File: tb/tb_phase_meas_ctrl.sv
// Scoreboard bench for phase_meas_ctrl (default build, CNT_W=8).
// Stimulus drives N/Q pin trains described as (period length, Q offset)
// per period; the expected results are derived from those pin timings and
// queued, and a monitor compares every presented result against the queue.
module tb_phase_meas_ctrl;

   localparam int unsigned CNT_W       = 8;
   localparam int unsigned SYNC_STAGES = 2;

   typedef struct packed {
      logic [CNT_W-1:0] ph;
      logic [CNT_W-1:0] per;
      logic             qm;
   } res_t;

   logic             clkRef = 1'b0;
   logic             rst_n, enable, N, Q, result_ready;
   logic [CNT_W-1:0] phase_cnt, period_cnt;
   logic             result_valid, q_missing, timeout, overrun, busy;

   res_t exp_q[$];
   res_t got;
   int   lens_q[$];
   int   offs_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   to_cnt = 0;
   int   first_to = -1;

   always #5 clkRef = ~clkRef;

   phase_meas_ctrl #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clkRef(clkRef), .rst_n(rst_n), .enable(enable), .N(N), .Q(Q),
      .phase_cnt(phase_cnt), .period_cnt(period_cnt),
      .result_valid(result_valid), .result_ready(result_ready),
      .q_missing(q_missing), .timeout(timeout), .overrun(overrun), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clkRef);
      #1;
   endtask

   // One train: a period per queue entry, then a closing N pulse.
   // off < 0 means no Q in that period; off == 0 is a Q rise coincident with N.
   task automatic train(input bit push_en);
      for (int i = 0; i < lens_q.size(); i++) begin
         if (push_en) begin
            res_t r;
            r.per = CNT_W'(lens_q[i]);
            // Q coincident with the opening edge of a train is not counted
            if (offs_q[i] < 0 || (offs_q[i] == 0 && i == 0)) begin
               r.ph = '0;
               r.qm = 1'b1;
            end else begin
               r.ph = CNT_W'(offs_q[i]);
               r.qm = 1'b0;
            end
            exp_q.push_back(r);
         end
         for (int c = 0; c < lens_q[i]; c++) begin
            N = (c < lens_q[i] / 2);
            Q = (offs_q[i] >= 0 && c >= offs_q[i] && c < offs_q[i] + 3);
            cycles(1);
         end
      end
      Q = 1'b0;
      for (int c = 0; c < 15; c++) begin
         N = (c < 5);
         cycles(1);
      end
   endtask

   task automatic fill(input int n, input int len, input int off);
      lens_q.delete();
      offs_q.delete();
      for (int i = 0; i < n; i++) begin
         lens_q.push_back(len);
         offs_q.push_back(off);
      end
   endtask

   task automatic drain(input string name);
      for (int w = 0; w < 50 && exp_q.size() != 0; w++) cycles(1);
      chk(name, exp_q.size(), 0);
   endtask

   // Abort and re-arm: back through IDLE into WAIT_N
   task automatic restart();
      enable = 1'b0;
      cycles(3);
      enable = 1'b1;
      cycles(3);
   endtask

   // Monitor: every presented result must match the queue head
   always @(negedge clkRef) begin
      cyc++;
      if (rst_n) begin
         if (timeout) begin
            to_cnt++;
            if (first_to < 0) first_to = cyc;
         end
         if (result_valid) begin
            got = '{ph: phase_cnt, per: period_cnt, qm: q_missing};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: got ph=%0d per=%0d qm=%0d, none expected",
                        got.ph, got.per, got.qm);
            end else begin
               if (got !== exp_q[0]) begin
                  errors++;
                  $display("FAIL result: got ph=%0d per=%0d qm=%0d expected ph=%0d per=%0d qm=%0d",
                           got.ph, got.per, got.qm, exp_q[0].ph, exp_q[0].per, exp_q[0].qm);
               end
               if (result_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst_n = 1'b0; enable = 1'b0; N = 1'b0; Q = 1'b0; result_ready = 1'b0;
      cycles(5);
      rst_n = 1'b1;
      cycles(50);

      // Reset / idle
      chk("rst_phase", phase_cnt, 0);
      chk("rst_period", period_cnt, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_qmiss", q_missing, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);

      result_ready = 1'b1;
      enable = 1'b1;
      cycles(3);
      chk("busy_wait_n", busy, 1);

      // Basic: period 100, Q lag 25
      fill(5, 100, 25);
      train(1'b1);
      drain("drain_basic");
      restart();

      // Missing Q: period 64
      fill(4, 64, -1);
      train(1'b1);
      drain("drain_missing");
      restart();

      // Coincident N/Q every 40 cycles
      fill(5, 40, 0);
      train(1'b1);
      drain("drain_coincident");
      restart();

      // Randomized trains
      for (int t = 0; t < 3; t++) begin
         lens_q.delete();
         offs_q.delete();
         for (int i = 0; i < 6; i++) begin
            int len, sel;
            len = int'($urandom_range(20, 200));
            sel = int'($urandom_range(0, 3));
            lens_q.push_back(len);
            if (sel == 0)      offs_q.push_back(-1);
            else if (sel == 1) offs_q.push_back(0);
            else               offs_q.push_back(int'($urandom_range(1, len - 4)));
         end
         train(1'b1);
         drain("drain_random");
         restart();
      end

      chk("no_spurious_timeout", to_cnt, 0);

      // Backpressure: only the first period is published, later ones dropped
      result_ready = 1'b0;
      fill(3, 100, 25);
      exp_q.push_back('{ph: CNT_W'(25), per: CNT_W'(100), qm: 1'b0});
      train(1'b0);
      chk("bp_valid_held", result_valid, 1);
      chk("bp_overrun", overrun, 1);
      result_ready = 1'b1;
      cycles(5);
      chk("bp_accepted", exp_q.size(), 0);
      chk("bp_valid_low", result_valid, 0);
      chk("bp_overrun_kept", overrun, 1);
      enable = 1'b0;
      cycles(2);
      chk("bp_overrun_clr", overrun, 0);
      chk("bp_idle", busy, 0);

      // Timeout: single N pulse, then nothing
      enable = 1'b1;
      cycles(3);
      to_cnt = 0;
      first_to = -1;
      t0 = cyc;
      N = 1'b1;
      cycles(5);
      N = 1'b0;
      cycles(300);
      chk("to_count", to_cnt, 1);
      chk("to_window", (first_to - t0 >= 255 && first_to - t0 <= 265) ? 1 : 0, 1);
      chk("to_no_valid", result_valid, 0);
      chk("to_busy", busy, 1);
      chk("to_timeout_low", timeout, 0);

      enable = 1'b0;
      cycles(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_phase_meas_ctrl

// File: doc/phase_meas_ctrl.md
Name: phase_meas_ctrl

Overview:
- Sequences phase measurement between the IR encoder channels N and Q, timed on the reference clock clkRef.
- Counts clkRef cycles from each N rising edge to the following Q rising edge (phase) and to the next N rising edge (period).
- Publishes each result over a valid/ready handshake to the display/LPF consumers.
- Owns timeout, missing-Q and overrun detection so downstream blocks only ever see qualified results.

Parameters:
- CNT_W, 16, width of cycle counter and of the phase/period outputs.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (legal values 2–3).

Ports:
- clkRef  in  1  reference clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run continuous measurement, 0 = abort and go idle.
- N  in  1  encoder channel N, asynchronous to clkRef.
- Q  in  1  encoder channel Q, asynchronous to clkRef.
- phase_cnt  out  CNT_W  cycles from N rise to Q rise, last published result.
- period_cnt  out  CNT_W  cycles from N rise to next N rise, last published result.
- result_valid  out  1  result available; held until accepted.
- result_ready  in  1  consumer accepts when result_valid && result_ready.
- q_missing  out  1  qualifier of the current result: no Q rise inside that period (phase_cnt = 0).
- timeout  out  1  one-cycle pulse: counter saturated without a closing N edge.
- overrun  out  1  sticky; a result was dropped because the previous one was unconsumed; cleared only by enable low.
- busy  out  1  high in WAIT_N and MEASURE.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counter 0; synchronizers 0.
- Input conditioning: N and Q each pass through SYNC_STAGES flops, then a rise detector (sync=1, previous=0).
  - Edge pulse appears SYNC_STAGES+1 clkRef cycles after the pin transition.
  - All counts below are relative to edge pulses, so input latency cancels.
- FSM states: IDLE, WAIT_N, MEASURE.
- IDLE:
  - busy=0; counter held at 0.
  - enable=1 -> WAIT_N on the next cycle.
- WAIT_N:
  - On N rise: counter <= 0, q_seen <= 0, go to MEASURE.
  - A Q rise in the same cycle is ignored.
- MEASURE:
  - Counter increments by 1 each cycle.
  - First Q rise with q_seen=0: phase_reg <= counter+1, q_seen <= 1. Later Q rises in the same period are ignored.
  - N rise (closing edge):
    - period = counter+1.
    - If result_valid=0 or a handshake completes this same cycle: load phase_cnt (phase_reg, or 0 if no Q), period_cnt, q_missing (= !q_seen), and set result_valid=1.
    - Otherwise drop the result and set overrun=1.
    - Then counter <= 0, q_seen <= 0; stay in MEASURE (back-to-back periods, no dead cycle).
  - Q rise coincident with the closing N rise belongs to the new period: captured as phase 0 of the new period, q_seen=1. The closing period reports q_missing=1 unless it had already seen a Q.
  - Counter reaches 2^CNT_W−1 with no N rise: pulse timeout for 1 cycle, discard the measurement, go to WAIT_N. No result is published.
- Handshake:
  - result_valid falls the cycle after valid&&ready.
  - Outputs are stable while result_valid=1 and unaccepted.
  - Publish takes priority over clear when both happen in the same cycle.
- enable=0 in any state:
  - Next cycle: IDLE, counter 0, overrun cleared, any in-flight measurement discarded.
  - result_valid and its data persist until accepted.
- Reset asserted mid-measurement: immediate return to reset values, including dropping result_valid.
- Arithmetic: unsigned, no wrap. Saturation is reported only via timeout.

Optional Feature:
- PHASE_MEAS_AVG_EN defined:
  - Block accumulates 4 consecutive valid periods into CNT_W+2 bit phase and period accumulators.
  - Publishes sum>>2 (truncated) once every 4th closing edge.
  - A period with q_missing or a timeout restarts the 4-count and clears the accumulators.
  - q_missing output is then always 0.
- Not defined: per-period publish as described above; no accumulators are synthesized.

Decomposition:
- Package phase_meas_pkg:
  - FSM state enum (IDLE, WAIT_N, MEASURE).
  - AVG_LOG2 = 2.
  - CNT_W default constant shared with the display and LPF blocks.
- One sub-module, edge_sync_rise: SYNC_STAGES synchronizer plus rise-detect pulse, instantiated once for N and once for Q.

Test Plan:
- Reset/idle: rst_n low, then enable=0 for 50 cycles -> all outputs 0, busy=0, no result_valid.
- Basic: enable=1, N square wave period 100 cycles, Q lagging 25 cycles, result_ready=1 -> each result phase_cnt=25, period_cnt=100, q_missing=0; first result on the second N edge.
- Backpressure: result_ready=0 for 250 cycles with period 100 -> first result held stable, overrun=1 after the second closing edge; raise ready -> data still from the first period; enable low clears overrun.
- Missing Q: Q held low, N period 64 -> period_cnt=64, phase_cnt=0, q_missing=1.
- Timeout: CNT_W=8, single N pulse then N held low -> timeout pulses once 255 cycles after the edge, no result_valid, busy stays 1 in WAIT_N.
- Coincident edges: N and Q rise on the same clkRef cycle every 40 cycles -> first result q_missing=1; subsequent results phase_cnt=0, period_cnt=40, q_missing=0. With PHASE_MEAS_AVG_EN and periods 100,101,102,103 -> one result period_cnt=101.
